// File: rtl/shift_out_driver.sv
// Serializes a parallel word MSB-first to a 74HC595-style shift register
// (data, shift clock, latch). All pin-facing outputs are driven straight from flops.
module shift_out_driver #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             ser_clk,
    output logic             ser_data,
    output logic             ser_latch,
    output logic             done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [BIT_W-1:0] BITS_ALL = BIT_W'(WIDTH);
    localparam logic [BIT_W-1:0] BITS_ONE = BIT_W'(1);
    localparam logic [BIT_W-1:0] BITS_ZERO = BIT_W'(0);
    localparam logic [WIDTH-1:0] WORD_ZERO = WIDTH'(0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [DIV_W-1:0] div_r, div_s;
    logic [BIT_W-1:0] bits_r, bits_s;
    logic [WIDTH-1:0] shreg_r, shreg_s;
    logic [WIDTH-1:0] shifted_s;
    logic             phase_end_s;
    logic             ready_r, ready_s;
    logic             ser_clk_r, ser_clk_s;
    logic             ser_data_r, ser_data_s;
    logic             ser_latch_r, ser_latch_s;
    logic             done_r, done_s;

    assign phase_end_s = (div_r == DIV_LAST);
    assign shifted_s   = shreg_r << 1'b1;

    // Next-state and next-output computation; the divider clears on every state change.
    always_comb begin
        state_s     = state_r;
        div_s       = div_r;
        bits_s      = bits_r;
        shreg_s     = shreg_r;
        ready_s     = ready_r;
        ser_clk_s   = ser_clk_r;
        ser_data_s  = ser_data_r;
        ser_latch_s = ser_latch_r;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                div_s = DIV_ZERO;
                if (valid && ready_r) begin
                    shreg_s    = data_in;
                    ser_data_s = data_in[WIDTH-1];
                    bits_s     = BITS_ALL;
                    ready_s    = 1'b0;
                    ser_clk_s  = 1'b0;
                    state_s    = SHIFT_LO;
                end else begin
                    ready_s = 1'b1;
                end
            end
            SHIFT_LO: begin
                if (phase_end_s) begin
                    div_s     = DIV_ZERO;
                    ser_clk_s = 1'b1;
                    state_s   = SHIFT_HI;
                end else begin
                    div_s = div_r + DIV_ONE;
                end
            end
            SHIFT_HI: begin
                if (phase_end_s) begin
                    div_s     = DIV_ZERO;
                    ser_clk_s = 1'b0;
                    if (bits_r > BITS_ONE) begin
                        shreg_s    = shifted_s;
                        ser_data_s = shifted_s[WIDTH-1];
                        bits_s     = bits_r - BITS_ONE;
                        state_s    = SHIFT_LO;
                    end else begin
                        ser_data_s  = 1'b0;
                        ser_latch_s = 1'b1;
                        state_s     = LATCH;
                    end
                end else begin
                    div_s = div_r + DIV_ONE;
                end
            end
            LATCH: begin
                if (phase_end_s) begin
                    div_s       = DIV_ZERO;
                    ser_latch_s = 1'b0;
                    done_s      = 1'b1;
                    ready_s     = 1'b1;
                    state_s     = IDLE;
                end else begin
                    div_s = div_r + DIV_ONE;
                end
            end
            default: begin
                state_s     = IDLE;
                div_s       = DIV_ZERO;
                bits_s      = BITS_ZERO;
                ready_s     = 1'b1;
                ser_clk_s   = 1'b0;
                ser_data_s  = 1'b0;
                ser_latch_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset also aborts a transfer silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            div_r       <= DIV_ZERO;
            bits_r      <= BITS_ZERO;
            shreg_r     <= WORD_ZERO;
            ready_r     <= 1'b1;
            ser_clk_r   <= 1'b0;
            ser_data_r  <= 1'b0;
            ser_latch_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            div_r       <= div_s;
            bits_r      <= bits_s;
            shreg_r     <= shreg_s;
            ready_r     <= ready_s;
            ser_clk_r   <= ser_clk_s;
            ser_data_r  <= ser_data_s;
            ser_latch_r <= ser_latch_s;
            done_r      <= done_s;
        end
    end

    assign ready     = ready_r;
    assign ser_clk   = ser_clk_r;
    assign ser_data  = ser_data_r;
    assign ser_latch = ser_latch_r;
    assign done      = done_r;

endmodule

// File: doc/shift_out_driver.md
Name: shift_out_driver

Overview:
Output-side counterpart to the board input synchronizers. It takes a parallel word from core logic over a valid/ready handshake and serializes it MSB-first to an external serial-in/parallel-out shift register (74HC595-style: data, shift clock, latch). Every pin-facing output comes straight from a flip-flop, so the board pins never see combinational glitches. It sits between game/display logic and the LED/segment expansion header.

Parameters:
WIDTH, 8, bits per transfer (WIDTH >= 1)
CLK_DIV, 4, clk cycles per ser_clk half-period (CLK_DIV >= 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  word to transmit; sampled only on handshake
valid  input  1  request to transmit data_in
ready  output  1  block idle and able to accept; registered
ser_clk  output  1  shift clock to external register; registered
ser_data  output  1  serial data, MSB first; registered
ser_latch  output  1  storage-register latch pulse; registered
done  output  1  one-cycle pulse when a transfer completes; registered

Behaviour:
- Reset is applied synchronously on the clk edge when reset=1. Reset values: ready=1, ser_clk=0, ser_data=0, ser_latch=0, done=0. State returns to IDLE, and the divider and bit counters clear. valid is ignored while reset=1.
- Reset mid-transfer aborts the transfer immediately, with no latch pulse and no done pulse. Outputs take their reset values on that edge.
- A single divider counter runs 0..CLK_DIV-1. A phase ends on the edge where the counter equals CLK_DIV-1; the counter clears on every state change.
- IDLE (ready=1):
  - On an edge where valid=1 and ready=1: capture data_in into the shift register, set ser_data<=data_in[WIDTH-1], bits_left<=WIDTH, ready<=0, ser_clk stays 0, go to SHIFT_LO.
  - valid while ready=0 is ignored. Requests are not queued; data_in is don't-care outside the handshake.
- SHIFT_LO: ser_clk=0 for CLK_DIV cycles, then ser_clk<=1 and go to SHIFT_HI. ser_data is stable for CLK_DIV cycles before each rising ser_clk.
- SHIFT_HI: ser_clk=1 for CLK_DIV cycles, then ser_clk<=0.
  - If bits_left>1: shift left, set ser_data<=next bit, decrement bits_left, go to SHIFT_LO.
  - If bits_left==1: set ser_data<=0, ser_latch<=1, go to LATCH.
- LATCH: ser_latch=1 for CLK_DIV cycles. On the final edge: ser_latch<=0, done<=1, ready<=1, go to IDLE.
- done is high for exactly one cycle: the first IDLE cycle, which is also the first cycle ready=1.
- A new valid may be accepted on the same edge that done deasserts. This allows back-to-back transfers with one idle cycle between them.
- Timing, counted from the accept edge (edge 0):
  - bit k (k=0 is MSB) rises at edge (2k+1)*CLK_DIV
  - falls at (2k+2)*CLK_DIV
  - ser_latch high from edge 2*WIDTH*CLK_DIV to (2*WIDTH+1)*CLK_DIV
  - ready low for exactly (2*WIDTH+1)*CLK_DIV cycles
  - Defaults: 68 cycles, with 8 rising ser_clk edges.
- ser_data changes only on edges where ser_clk goes 0 (or at accept), never while ser_clk=1.
- Exactly WIDTH rising ser_clk edges per transfer, and exactly one latch pulse per completed transfer.
- WIDTH=1 case: one clock pulse, then LATCH.
- CLK_DIV=1 case: ser_clk toggles every cycle, and phases last one cycle each.

Test Plan:
1. Reset, then hold idle 10 cycles -> ready=1; ser_clk, ser_data, ser_latch and done all 0 throughout.
2. WIDTH=8, CLK_DIV=4, send 0xA5 -> ser_data sampled at the 8 ser_clk rises reads 1,0,1,0,0,1,0,1. ser_latch is high cycles 64-67. done pulses at cycle 68, and ready is low for exactly 68 cycles.
3. valid=1 with 0xFF at cycle 10 of a 0x3C transfer -> ignored. Shifted bits are 0,0,1,1,1,1,0,0, and exactly one done pulse.
4. Assert reset at cycle 30 of a 0x81 transfer -> next cycle ready=1 and all pin outputs 0. No latch or done pulse. A following 0x81 transfer is then sent correctly.
5. valid held high continuously with data 0x01 then 0x80 -> two transfers, second accepted on the done cycle. Ser bits read 00000001 then 10000000, with 2 latch pulses and 2 done pulses.
6. WIDTH=4, CLK_DIV=1, send 0x9 -> ser_clk toggles every cycle with bits 1,0,0,1. Latch is high one cycle at cycle 8, and done is at cycle 9.
